// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB bus arbiter that holds ownership across fixed and
// undefined-length bursts. Bus locking is compiled in only when ARB_HLOCK_EN is defined.
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int MW             = 2,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCKREQ,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK,
    output logic                   arb_busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_INCR  = 2'd2;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] BU_SINGLE = 3'd0;
    localparam logic [2:0] BU_INCR   = 3'd1;

    localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

    // Remaining beats after the NONSEQ beat; wrapping and incrementing variants share a length.
    function automatic logic [3:0] burst_len_f(input logic [2:0] burst);
        logic [3:0] len;
        case (burst[2:1])
            2'b01:   len = 4'd3;
            2'b10:   len = 4'd7;
            2'b11:   len = 4'd15;
            default: len = 4'd0;
        endcase
        return len;
    endfunction

    function automatic logic [NUM_MASTERS-1:0] onehot_f(input logic [MW-1:0] idx);
        logic [NUM_MASTERS-1:0] vec;
        vec      = {NUM_MASTERS{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [3:0]    cnt_r;
    logic [3:0]    cnt_nxt_s;
    logic [MW-1:0] rr_r;
    logic [MW-1:0] winner_s;
    logic          rearb_s;
    logic          owner_req_s;
    logic          lock_nxt_s;
    int            dist_v;
    int            best_v;

    assign owner_req_s = HBUSREQ[HMASTER];
    assign arb_busy    = (state_r != ST_IDLE);

`ifdef ARB_HLOCK_EN
    logic owner_lock_s;
    logic lock_r;
    assign owner_lock_s = HLOCKREQ[HMASTER];
    assign HMASTLOCK    = lock_r;
`else
    logic unused_s;
    assign unused_s  = ^HLOCKREQ;
    assign HMASTLOCK = 1'b0;
`endif

    // Round-robin winner: smallest forward distance from rr_r+1, parking on DEFAULT_MASTER.
    always_comb begin
        winner_s   = DEF_IDX;
        lock_nxt_s = 1'b0;
        best_v     = NUM_MASTERS;
        dist_v     = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            dist_v = i - int'(rr_r) - 1;
            if (dist_v < 0) begin
                dist_v = dist_v + NUM_MASTERS;
            end else begin
                dist_v = dist_v;
            end
            if (HBUSREQ[i] && (dist_v < best_v)) begin
                best_v   = dist_v;
                winner_s = MW'(i);
            end else begin
                best_v   = best_v;
            end
        end
`ifdef ARB_HLOCK_EN
        if (owner_lock_s) begin
            winner_s   = HMASTER;
            lock_nxt_s = 1'b1;
        end else begin
            lock_nxt_s = 1'b0;
        end
`endif
    end

    // Burst tracking FSM and re-arbitration point detection; HREADY=0 holds everything.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        rearb_s     = 1'b0;
        if (HREADY) begin
            case (state_r)
                ST_IDLE: begin
                    if (HTRANS == TR_NONSEQ) begin
                        cnt_nxt_s = burst_len_f(HBURST);
                        if (HBURST == BU_SINGLE) begin
                            rearb_s = 1'b1;
                        end else if (HBURST == BU_INCR) begin
                            state_nxt_s = ST_INCR;
                        end else begin
                            state_nxt_s = ST_BURST;
                        end
                    end else begin
                        rearb_s = 1'b1;
                    end
                end
                ST_BURST: begin
                    if (HTRANS == TR_SEQ) begin
                        if (cnt_r <= 4'd1) begin
                            cnt_nxt_s   = 4'd0;
                            state_nxt_s = ST_IDLE;
                            rearb_s     = 1'b1;
                        end else begin
                            cnt_nxt_s = cnt_r - 4'd1;
                        end
                    end else if ((HTRANS == TR_IDLE) || (HTRANS == TR_NONSEQ)) begin
                        // Early termination by the owner aborts the burst.
                        cnt_nxt_s   = 4'd0;
                        state_nxt_s = ST_IDLE;
                        rearb_s     = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                ST_INCR: begin
                    if (!owner_req_s && ((HTRANS == TR_IDLE) || (HTRANS == TR_NONSEQ))) begin
                        state_nxt_s = ST_IDLE;
                        rearb_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_INCR;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, counter, pointer and registered grant outputs.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            rr_r    <= DEF_IDX;
            HGRANT  <= onehot_f(DEF_IDX);
            HMASTER <= DEF_IDX;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (rearb_s) begin
                rr_r    <= winner_s;
                HGRANT  <= onehot_f(winner_s);
                HMASTER <= winner_s;
            end else begin
                rr_r    <= rr_r;
                HGRANT  <= HGRANT;
                HMASTER <= HMASTER;
            end
        end
    end

`ifdef ARB_HLOCK_EN
    // Lock status follows the owner's HLOCKREQ sampled at each re-arbitration point.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            lock_r <= 1'b0;
        end else if (rearb_s) begin
            lock_r <= lock_nxt_s;
        end else begin
            lock_r <= lock_r;
        end
    end
`else
    logic unused_lock_s;
    assign unused_lock_s = lock_nxt_s;
`endif

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: vector table plus hand sequences for reset and locking.
module tb_ahb_bus_arbiter;

    localparam int NM = 4;
    localparam int MW = 2;

    localparam logic [1:0] IDL = 2'b00;
    localparam logic [1:0] BSY = 2'b01;
    localparam logic [1:0] NSQ = 2'b10;
    localparam logic [1:0] SEQ = 2'b11;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [NM-1:0] HBUSREQ;
    logic [NM-1:0] HLOCKREQ;
    logic [1:0]    HTRANS;
    logic [2:0]    HBURST;
    logic          HREADY;
    logic [NM-1:0] HGRANT;
    logic [MW-1:0] HMASTER;
    logic          HMASTLOCK;
    logic          arb_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 HCLK = ~HCLK;

    ahb_bus_arbiter #(
        .NUM_MASTERS   (NM),
        .MW            (MW),
        .DEFAULT_MASTER(0)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .HBUSREQ  (HBUSREQ),
        .HLOCKREQ (HLOCKREQ),
        .HTRANS   (HTRANS),
        .HBURST   (HBURST),
        .HREADY   (HREADY),
        .HGRANT   (HGRANT),
        .HMASTER  (HMASTER),
        .HMASTLOCK(HMASTLOCK),
        .arb_busy (arb_busy)
    );

    typedef struct {
        logic          rst;
        logic [NM-1:0] req;
        logic [1:0]    trans;
        logic [2:0]    burst;
        logic          rdy;
        logic [NM-1:0] e_grant;
        logic [MW-1:0] e_master;
        logic          e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [NM-1:0] req, input logic [1:0] trans,
                       input logic [2:0] burst, input logic rdy, input logic [NM-1:0] eg,
                       input logic [MW-1:0] em, input logic eb);
        vec_t v;
        v.rst = rst; v.req = req; v.trans = trans; v.burst = burst; v.rdy = rdy;
        v.e_grant = eg; v.e_master = em; v.e_busy = eb;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [NM-1:0] req, input logic [NM-1:0] lock,
                         input logic [1:0] trans, input logic [2:0] burst, input logic rdy);
        HRESET   = rst;
        HBUSREQ  = req;
        HLOCKREQ = lock;
        HTRANS   = trans;
        HBURST   = burst;
        HREADY   = rdy;
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [NM-1:0] eg, input logic [MW-1:0] em,
                         input logic el, input logic eb);
        n_tests++;
        if (HGRANT !== eg || HMASTER !== em || HMASTLOCK !== el || arb_busy !== eb) begin
            n_fail++;
            $display("FAIL %s: got grant=%b master=%0d lock=%b busy=%b, expected grant=%b master=%0d lock=%b busy=%b",
                     name, HGRANT, HMASTER, HMASTLOCK, arb_busy, eg, em, el, eb);
        end
    endtask

    initial begin
        HRESET = 1'b1; HBUSREQ = 4'b0000; HLOCKREQ = 4'b0000;
        HTRANS = IDL; HBURST = 3'd0; HREADY = 1'b1;

        // reset held two cycles
        add(1'b1, 4'b0000, IDL, 3'd0, 1'b1, 4'b0001, 2'd0, 1'b0);
        add(1'b1, 4'b0000, IDL, 3'd0, 1'b1, 4'b0001, 2'd0, 1'b0);
        // round robin between M1 and M2 on SINGLE transfers, then park on M0
        add(1'b0, 4'b0110, IDL, 3'd0, 1'b1, 4'b0010, 2'd1, 1'b0);
        add(1'b0, 4'b0110, NSQ, 3'd0, 1'b1, 4'b0100, 2'd2, 1'b0);
        add(1'b0, 4'b0110, NSQ, 3'd0, 1'b1, 4'b0010, 2'd1, 1'b0);
        add(1'b0, 4'b0110, NSQ, 3'd0, 1'b1, 4'b0100, 2'd2, 1'b0);
        add(1'b0, 4'b0000, IDL, 3'd0, 1'b1, 4'b0001, 2'd0, 1'b0);
        add(1'b0, 4'b0110, IDL, 3'd0, 1'b0, 4'b0001, 2'd0, 1'b0);
        // M2 INCR8 with M3 pending, two wait states on beat 3 and one BUSY
        add(1'b0, 4'b0100, IDL, 3'd0, 1'b1, 4'b0100, 2'd2, 1'b0);
        add(1'b0, 4'b1100, NSQ, 3'd5, 1'b1, 4'b0100, 2'd2, 1'b1);
        add(1'b0, 4'b1100, SEQ, 3'd5, 1'b1, 4'b0100, 2'd2, 1'b1);
        add(1'b0, 4'b1100, SEQ, 3'd5, 1'b0, 4'b0100, 2'd2, 1'b1);
        add(1'b0, 4'b1100, SEQ, 3'd5, 1'b0, 4'b0100, 2'd2, 1'b1);
        add(1'b0, 4'b1100, SEQ, 3'd5, 1'b1, 4'b0100, 2'd2, 1'b1);
        add(1'b0, 4'b1100, SEQ, 3'd5, 1'b1, 4'b0100, 2'd2, 1'b1);
        add(1'b0, 4'b1100, SEQ, 3'd5, 1'b1, 4'b0100, 2'd2, 1'b1);
        add(1'b0, 4'b1100, BSY, 3'd5, 1'b1, 4'b0100, 2'd2, 1'b1);
        add(1'b0, 4'b1100, SEQ, 3'd5, 1'b1, 4'b0100, 2'd2, 1'b1);
        add(1'b0, 4'b1100, SEQ, 3'd5, 1'b1, 4'b0100, 2'd2, 1'b1);
        add(1'b0, 4'b1100, SEQ, 3'd5, 1'b1, 4'b1000, 2'd3, 1'b0);
        // M1 undefined-length INCR, M0 pending
        add(1'b0, 4'b0010, IDL, 3'd0, 1'b1, 4'b0010, 2'd1, 1'b0);
        add(1'b0, 4'b0011, NSQ, 3'd1, 1'b1, 4'b0010, 2'd1, 1'b1);
        for (int k = 0; k < 5; k++)
            add(1'b0, 4'b0011, SEQ, 3'd1, 1'b1, 4'b0010, 2'd1, 1'b1);
        add(1'b0, 4'b0011, IDL, 3'd1, 1'b1, 4'b0010, 2'd1, 1'b1);
        add(1'b0, 4'b0001, SEQ, 3'd1, 1'b1, 4'b0010, 2'd1, 1'b1);
        add(1'b0, 4'b0001, IDL, 3'd1, 1'b0, 4'b0010, 2'd1, 1'b1);
        add(1'b0, 4'b0001, IDL, 3'd1, 1'b1, 4'b0001, 2'd0, 1'b0);
        // M3 INCR4 aborted by IDLE after beat 2
        add(1'b0, 4'b1000, IDL, 3'd0, 1'b1, 4'b1000, 2'd3, 1'b0);
        add(1'b0, 4'b1001, NSQ, 3'd3, 1'b1, 4'b1000, 2'd3, 1'b1);
        add(1'b0, 4'b1001, SEQ, 3'd3, 1'b1, 4'b1000, 2'd3, 1'b1);
        add(1'b0, 4'b1001, IDL, 3'd3, 1'b1, 4'b0001, 2'd0, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req, 4'b0000, vecs[i].trans, vecs[i].burst, vecs[i].rdy);
            check($sformatf("vec%0d", i), vecs[i].e_grant, vecs[i].e_master, 1'b0, vecs[i].e_busy);
        end

        // reset in the middle of an INCR16
        drive(1'b0, 4'b0100, 4'b0000, IDL, 3'd0, 1'b1);
        check("incr16_grant", 4'b0100, 2'd2, 1'b0, 1'b0);
        drive(1'b0, 4'b0110, 4'b0000, NSQ, 3'd7, 1'b1);
        check("incr16_start", 4'b0100, 2'd2, 1'b0, 1'b1);
        drive(1'b0, 4'b0110, 4'b0000, SEQ, 3'd7, 1'b1);
        drive(1'b0, 4'b0110, 4'b0000, SEQ, 3'd7, 1'b1);
        check("incr16_mid", 4'b0100, 2'd2, 1'b0, 1'b1);
        drive(1'b1, 4'b0110, 4'b0000, SEQ, 3'd7, 1'b1);
        check("reset_mid_burst", 4'b0001, 2'd0, 1'b0, 1'b0);
        drive(1'b0, 4'b0110, 4'b0000, IDL, 3'd0, 1'b1);
        check("post_reset_rr", 4'b0010, 2'd1, 1'b0, 1'b0);

`ifdef ARB_HLOCK_EN
        // M1 locks across three SINGLE transfers while M2 requests
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'b0110, 4'b0010, NSQ, 3'd0, 1'b1);
            check($sformatf("lock_hold%0d", k), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        drive(1'b0, 4'b0110, 4'b0000, NSQ, 3'd0, 1'b1);
        check("lock_release", 4'b0100, 2'd2, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
